keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Synthesizable model of the 4x4 matrix keypad that answers the column scanner: it watches the one-hot column drive and returns the row lines a physical keypad would produce for a commanded key press, including contact bounce on make and break. It sits between a stimulus source and the keypad scanner input, and is used for hardware-in-the-loop and bench checks of the scan/decode/display path without a physical keypad.

## Interface
- HOLD_CYCLES, 1000000: cycles the key is held solidly closed (minimum 1).
- BOUNCE_CYCLES, 5000: cycles of chatter on make and again on break (0 = no chatter).
- LFSR_SEED, 16'hACE1: reset value of the chatter LFSR (must be nonzero).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cols  input  4  column drive from the scanner, active-high, one-hot expected.
- rows  output  4  row return to the scanner, active-high, registered.
- key_code  input  4  key to press: row = key_code[3:2], column = key_code[1:0].
- press_valid  input  1  press request; accepted when press_valid && press_ready.
- press_ready  output  1  high only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the cycle that returns to IDLE after a press.

## Operation
- The accepted key_code is latched into key_r. Later changes on key_code are ignored until the next accept.
- contact is an internal 1-bit signal. The key is electrically closed when contact = 1.
- Row model, evaluated every cycle: rows_next[r] = contact && (r == key_r[3:2]) && cols[key_r[1:0]].
- Any cols pattern is allowed, including non-one-hot or all-zero. Only the bit for the latched column matters.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). It advances every cycle in the bounce states and holds otherwise. chatter = lfsr[0].
- Counter cnt: wide enough for max(HOLD_CYCLES, BOUNCE_CYCLES). Loaded with N-1 on entry to a timed state; that state lasts N cycles, and the state exits when cnt == 0.
- State machine:
  - IDLE: contact = 0. On accept, go to BOUNCE_IN, or to HOLD if BOUNCE_CYCLES == 0.
  - BOUNCE_IN (BOUNCE_CYCLES cycles): contact = chatter. Forced to 1 on the final cycle. Then go to HOLD.
  - HOLD (HOLD_CYCLES cycles): contact = 1. Then go to BOUNCE_OUT, or to DONE if BOUNCE_CYCLES == 0.
  - BOUNCE_OUT (BOUNCE_CYCLES cycles): contact = chatter. Forced to 0 on the final cycle. Then go to DONE.
  - DONE (1 cycle): contact = 0, done = 1. Then go to IDLE.
- press_valid while busy is not accepted and is not queued.
- Reset:
  - Values: state = IDLE, rows = 4'b0000, press_ready = 1, busy = 0, done = 0, key_r = 0, cnt = 0, lfsr = LFSR_SEED.
  - Reset mid-press abandons the press: done does not pulse, and rows read 0 on the first cycle after reset.

## Timing
- Accept at edge k:
  - First non-IDLE state is active in cycle k+1, and press_ready drops in that cycle.
  - The earliest possible nonzero rows appear at edge k+2, because rows are registered.
- cols to rows latency is 1 cycle (registered), in every state.
- With bounce enabled:
  - Press duration from accept to the done pulse is 2*BOUNCE_CYCLES + HOLD_CYCLES + 1 cycles.
  - The next accept is possible on the cycle after done.
- Solid contact is guaranteed from the last BOUNCE_IN cycle through the last HOLD cycle, which is HOLD_CYCLES+1 consecutive cycles.
- done and press_ready are never high in the same cycle. busy is exactly the complement of press_ready.
- The LFSR is never reseeded except by rst, so the chatter sequence continues from press to press.

## Test plan
- Reset then idle: rst high for 2 cycles, cols cycled 0001→0010→0100→1000 → rows = 0000 throughout, press_ready = 1, busy = 0.
- Clean press (BOUNCE_CYCLES=0, HOLD_CYCLES=8), key_code = 4'b0110 (row 1, col 2), cols held 0100 → rows = 0010 for exactly 8 cycles, starting 2 cycles after accept; done pulses 9 cycles after accept; rows = 0000 while cols = 0001, 0010 or 1000.
- Bounce (BOUNCE_CYCLES=6, HOLD_CYCLES=4, seed ACE1), key_code = 4'hF, cols = 1000 → rows[3] follows the reference-model LFSR chatter for 5 cycles, then is 1 for 5 consecutive cycles, then chatters, then is 0 on the final bounce-out cycle; done at accept+17.
- Busy rejection: second press_valid with key_code 4'h0 asserted mid-HOLD → ignored, row/col still those of the first key, single done pulse; new accept is possible the cycle after done.
- Reset mid-HOLD → rows = 0000 on the next cycle, no done pulse, press_ready = 1, LFSR back to ACE1.
- Scanner loop: emulator wired to the keypad scanner and 7-seg decoder, press each of the 16 keys → scanner output code matches key_code and the display pattern matches the decoder table for every key.

Source files
------------

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model answering a column scanner, with LFSR
// contact chatter on make and break of each commanded key press.
module keypad_emulator #(
   parameter int unsigned HOLD_CYCLES   = 1000000,
   parameter int unsigned BOUNCE_CYCLES = 5000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   input  logic [3:0] key_code,
   input  logic       press_valid,
   output logic       press_ready,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MAXC =
      (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam bit NOBNC = (BOUNCE_CYCLES == 0);
   localparam int unsigned HOLD_M1 =
      (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
   localparam int unsigned BNC_M1 =
      (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_M1);
   localparam logic [CW-1:0] BNC_LD  = CW'(BNC_M1);
   localparam logic [15:0] TAPS = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIN,
      S_HOLD,
      S_BOUT,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [3:0]    key_r;
   logic [3:0]    key_nx;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_nx;
   logic [3:0]    rows_nx;
   logic          contact;
   logic          last;
   logic          bouncing;

   assign last     = (cnt == '0);
   assign bouncing = (state == S_BIN) || (state == S_BOUT);

   // Chatter sequence free-runs across presses; only rst reseeds it.
   always_comb begin
      lfsr_nx = lfsr;
      if (bouncing)
         lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      key_nx      = key_r;
      contact     = 1'b0;
      press_ready = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state)
         S_IDLE: begin
            press_ready = 1'b1;
            busy        = 1'b0;
            if (press_valid) begin
               key_nx = key_code;
               if (NOBNC) begin
                  state_nx = S_HOLD;
                  cnt_nx   = HOLD_LD;
               end else begin
                  state_nx = S_BIN;
                  cnt_nx   = BNC_LD;
               end
            end
         end
         S_BIN: begin
            contact = last | lfsr[0];
            if (last) begin
               state_nx = S_HOLD;
               cnt_nx   = HOLD_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_HOLD: begin
            contact = 1'b1;
            if (last) begin
               if (NOBNC) begin
                  state_nx = S_DONE;
                  cnt_nx   = '0;
               end else begin
                  state_nx = S_BOUT;
                  cnt_nx   = BNC_LD;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_BOUT: begin
            contact = ~last & lfsr[0];
            if (last)
               state_nx = S_DONE;
            else
               cnt_nx = cnt - 1'b1;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rows_nx = 4'b0000;
      if (contact && cols[key_r[1:0]])
         rows_nx = 4'b0001 << key_r[3:2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         key_r <= 4'h0;
         lfsr  <= LFSR_SEED;
         rows  <= 4'b0000;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         key_r <= key_nx;
         lfsr  <= lfsr_nx;
         rows  <= rows_nx;
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: clean and bouncing instances checked
// against a cycle-indexed press model with its own chatter LFSR.
module tb_keypad_emulator;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       pv_c;
   logic       pv_b;
   logic [3:0] rows_c;
   logic [3:0] rows_b;
   logic       rdy_c;
   logic       rdy_b;
   logic       busy_c;
   logic       busy_b;
   logic       done_c;
   logic       done_b;

   int checks = 0;
   int errors = 0;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   keypad_emulator #(
      .HOLD_CYCLES(8),
      .BOUNCE_CYCLES(0),
      .LFSR_SEED(SEED)
   ) u_clean (
      .clk(clk),
      .rst(rst),
      .cols(cols),
      .rows(rows_c),
      .key_code(key_code),
      .press_valid(pv_c),
      .press_ready(rdy_c),
      .busy(busy_c),
      .done(done_c)
   );

   keypad_emulator #(
      .HOLD_CYCLES(4),
      .BOUNCE_CYCLES(6),
      .LFSR_SEED(SEED)
   ) u_bnc (
      .clk(clk),
      .rst(rst),
      .cols(cols),
      .rows(rows_b),
      .key_code(key_code),
      .press_valid(pv_b),
      .press_ready(rdy_b),
      .busy(busy_b),
      .done(done_b)
   );

   task automatic chat(output logic c);
      c = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   endtask

   // Contact level in cycle j after accept, from the press timeline.
   task automatic model_contact(input int j, input int b,
                                input int h, output logic c);
      logic ch;
      if (j < b) begin
         chat(ch);
         c = (j == b - 1) ? 1'b1 : ch;
      end else if (j < b + h) begin
         c = 1'b1;
      end else if (j < 2 * b + h) begin
         chat(ch);
         c = (j == 2 * b + h - 1) ? 1'b0 : ch;
      end else begin
         c = 1'b0;
      end
   endtask

   task automatic sample(input bit w, output logic [3:0] r,
                         output logic rd, output logic bz,
                         output logic dn);
      r  = w ? rows_b : rows_c;
      rd = w ? rdy_b  : rdy_c;
      bz = w ? busy_b : busy_c;
      dn = w ? done_b : done_c;
   endtask

   task automatic press(input bit w, input logic [3:0] key,
                        input bit rnd, input logic [3:0] fc,
                        input int intr_at, input int rst_at,
                        input string nm);
      int b = w ? 6 : 0;
      int h = w ? 4 : 8;
      int t = 2 * b + h;
      logic [3:0] r;
      logic [3:0] exp;
      logic rd, bz, dn, c;
      sample(w, r, rd, bz, dn);
      checks++;
      if (rd !== 1'b1 || bz !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: ready=%b busy=%b want 1 0",
                  nm, rd, bz);
      end
      key_code = key;
      if (w) pv_b = 1'b1;
      else   pv_c = 1'b1;
      cols = rnd ? 4'($urandom) : fc;
      exp  = 4'b0000;
      for (int j = 0; j <= t; j++) begin
         @(negedge clk);
         sample(w, r, rd, bz, dn);
         checks++;
         if (r !== exp) begin
            errors++;
            $display("FAIL %s rows j=%0d: got %b want %b",
                     nm, j, r, exp);
         end
         checks++;
         if (dn !== (j == t)) begin
            errors++;
            $display("FAIL %s done j=%0d: got %b want %b",
                     nm, j, dn, (j == t));
         end
         checks++;
         if (rd !== 1'b0 || bz !== 1'b1) begin
            errors++;
            $display("FAIL %s busy j=%0d: ready=%b busy=%b want 0 1",
                     nm, j, rd, bz);
         end
         pv_c = 1'b0;
         pv_b = 1'b0;
         key_code = 4'($urandom);
         if (j == intr_at) begin
            key_code = 4'h0;
            if (w) pv_b = 1'b1;
            else   pv_c = 1'b1;
         end
         if (j == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            m_lfsr = SEED;
            sample(w, r, rd, bz, dn);
            checks++;
            if (r !== 4'b0000 || rd !== 1'b1 ||
                bz !== 1'b0 || dn !== 1'b0) begin
               errors++;
               $display("FAIL %s after rst: rows=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                        nm, r, rd, bz, dn);
            end
            for (int k = 0; k < t + 2; k++) begin
               cols = 4'($urandom);
               @(negedge clk);
               sample(w, r, rd, bz, dn);
               checks++;
               if (dn !== 1'b0 || r !== 4'b0000) begin
                  errors++;
                  $display("FAIL %s abandoned k=%0d: done=%b rows=%b want 0 0000",
                           nm, k, dn, r);
               end
            end
            return;
         end
         model_contact(j, b, h, c);
         cols = rnd ? 4'($urandom) : fc;
         exp = (c && cols[key[1:0]]) ? (4'b0001 << key[3:2])
                                     : 4'b0000;
      end
      @(negedge clk);
      sample(w, r, rd, bz, dn);
      checks++;
      if (r !== exp || dn !== 1'b0 || rd !== 1'b1 || bz !== 1'b0) begin
         errors++;
         $display("FAIL %s end: rows=%b done=%b rdy=%b busy=%b want %b 0 1 0",
                  nm, r, dn, rd, bz, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_lfsr = SEED;
      for (int i = 0; i < 4; i++) begin
         cols = 4'b0001 << i;
         if (i == 2) rst = 1'b0;
         @(negedge clk);
         checks++;
         if (rows_c !== 4'b0000 || rows_b !== 4'b0000 ||
             rdy_c !== 1'b1 || rdy_b !== 1'b1 ||
             busy_c !== 1'b0 || busy_b !== 1'b0 ||
             done_c !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset i=%0d: rows=%b/%b rdy=%b/%b busy=%b/%b done=%b/%b",
                     i, rows_c, rows_b, rdy_c, rdy_b,
                     busy_c, busy_b, done_c, done_b);
         end
      end
   endtask

   task automatic test_clean();
      press(1'b0, 4'b0110, 1'b0, 4'b0100, -1, -1, "clean");
      press(1'b0, 4'b0110, 1'b1, 4'b0000, -1, -1, "clean_rnd");
   endtask

   task automatic test_bounce();
      press(1'b1, 4'hF, 1'b0, 4'b1000, -1, -1, "bounce");
   endtask

   task automatic test_busy_reject();
      press(1'b1, 4'h9, 1'b1, 4'b0000, 8, -1, "reject_b");
      press(1'b0, 4'hA, 1'b1, 4'b0000, 3, -1, "reject_c");
   endtask

   task automatic test_back_to_back();
      press(1'b1, 4'h5, 1'b0, 4'b0010, -1, -1, "b2b_b0");
      press(1'b1, 4'hC, 1'b1, 4'b0000, -1, -1, "b2b_b1");
      press(1'b0, 4'h3, 1'b1, 4'b0000, -1, -1, "b2b_c0");
      press(1'b0, 4'hE, 1'b1, 4'b0000, -1, -1, "b2b_c1");
   endtask

   task automatic test_reset_mid_hold();
      press(1'b1, 4'h7, 1'b0, 4'b1000, -1, 8, "rst_hold");
      press(1'b1, 4'hB, 1'b0, 4'b1000, -1, -1, "after_rst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         press(1'b1, 4'($urandom), 1'b1, 4'b0000, -1, -1, "rnd_b");
      for (int i = 0; i < 4; i++)
         press(1'b0, 4'($urandom), 1'b1, 4'b0000, -1, -1, "rnd_c");
   endtask

   function automatic logic [1:0] idx(input logic [3:0] v);
      logic [1:0] n = 2'd0;
      for (int i = 0; i < 4; i++)
         if (v[i]) n = 2'(i);
      return n;
   endfunction

   task automatic test_scanner();
      logic [3:0] code;
      bit found;
      for (int k = 0; k < 16; k++) begin
         key_code = 4'(k);
         pv_c  = 1'b1;
         cols  = 4'b0001;
         found = 1'b0;
         code  = 4'h0;
         for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            pv_c = 1'b0;
            if (!found && rows_c !== 4'b0000) begin
               found = 1'b1;
               code  = {idx(rows_c), idx(cols)};
            end
            cols = {cols[2:0], cols[3]};
         end
         checks++;
         if (!found || code !== 4'(k) || rdy_c !== 1'b1) begin
            errors++;
            $display("FAIL scan key=%0d: found=%0b code=%0d rdy=%b want code %0d",
                     k, found, code, rdy_c, k);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      pv_c     = 1'b0;
      pv_b     = 1'b0;
      key_code = 4'h0;
      cols     = 4'b0000;
      test_reset();
      test_clean();
      test_bounce();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid_hold();
      test_random();
      test_scanner();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
